// File: rtl/io_interface_if.sv
// Device and control-unit signal bundle for the basic computer I/O block.
// slave: the I/O block; master: devices plus control unit.
interface io_interface_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] kbd_data;
  logic              kbd_valid;
  logic              kbd_ready;
  logic [DATA_W-1:0] prn_data;
  logic              prn_valid;
  logic              prn_ready;
  logic              inp_ack;
  logic              out_load;
  logic [DATA_W-1:0] out_data;
  logic              ion;
  logic              iof;
  logic              fetch_phase;
  logic              intr_ack;
  logic [DATA_W-1:0] inpr;
  logic              fgi;
  logic              fgo;
  logic              ien;
  logic              r;

  modport slave (
    input  kbd_data, kbd_valid, prn_ready,
    input  inp_ack, out_load, out_data,
    input  ion, iof, fetch_phase, intr_ack,
    output kbd_ready, prn_data, prn_valid,
    output inpr, fgi, fgo, ien, r
  );

  modport master (
    output kbd_data, kbd_valid, prn_ready,
    output inp_ack, out_load, out_data,
    output ion, iof, fetch_phase, intr_ack,
    input  kbd_ready, prn_data, prn_valid,
    input  inpr, fgi, fgo, ien, r
  );
endinterface

// File: rtl/io_interface.sv
// Keyboard/printer interface: INPR/OUTR, FGI/FGO, IEN and R flip-flops.
// Printer side is a two-state IDLE/SEND handshake FSM.
module io_interface #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           clr,
  io_interface_if.slave  bus
);
  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] inpr_q, inpr_nx;
  logic [DATA_W-1:0] outr_q, outr_nx;
  logic fgi_q, fgi_nx;
  logic fgo_q, fgo_nx;
  logic pv_q, pv_nx;
  logic ien_q, ien_nx;
  logic r_q, r_nx;
  logic take;

  assign take = bus.kbd_valid & ~fgi_q;

  always_comb begin
    inpr_nx  = inpr_q;
    fgi_nx   = fgi_q;
    outr_nx  = outr_q;
    fgo_nx   = fgo_q;
    pv_nx    = pv_q;
    state_nx = state;
    ien_nx   = ien_q;
    r_nx     = r_q;

    if (take) begin
      inpr_nx = bus.kbd_data;
      fgi_nx  = 1'b1;
    end else if (bus.inp_ack && fgi_q) begin
      fgi_nx = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (bus.out_load) begin
          outr_nx  = bus.out_data;
          fgo_nx   = 1'b0;
          pv_nx    = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (bus.prn_ready) begin
          fgo_nx   = 1'b1;
          pv_nx    = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // clears outrank ion
    if (bus.intr_ack || bus.iof)
      ien_nx = 1'b0;
    else if (bus.ion)
      ien_nx = 1'b1;

    if (bus.intr_ack)
      r_nx = 1'b0;
    else if (!bus.fetch_phase && ien_q
             && (fgi_q || fgo_q))
      r_nx = 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      inpr_q <= '0;
      outr_q <= '0;
      fgi_q  <= 1'b0;
      fgo_q  <= 1'b1;
      pv_q   <= 1'b0;
      ien_q  <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      inpr_q <= inpr_nx;
      outr_q <= outr_nx;
      fgi_q  <= fgi_nx;
      fgo_q  <= fgo_nx;
      pv_q   <= pv_nx;
      ien_q  <= ien_nx;
      r_q    <= r_nx;
    end
  end

  assign bus.kbd_ready = ~fgi_q;
  assign bus.prn_data  = outr_q;
  assign bus.prn_valid = pv_q;
  assign bus.inpr      = inpr_q;
  assign bus.fgi       = fgi_q;
  assign bus.fgo       = fgo_q;
  assign bus.ien       = ien_q;
  assign bus.r         = r_q;
endmodule

// File: tb/tb_io_interface.sv
// Bench for io_interface: directed plan steps then random traffic
// against a queue-based reference model.
module tb_io_interface;
  localparam int W = 8;

  logic clk = 1'b0;
  logic clr;

  io_interface_if #(.DATA_W(W)) bus ();

  io_interface #(.DATA_W(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_inpr;
  logic [W-1:0] m_outr;
  logic [W-1:0] prn_q[$];
  bit m_fgi, m_ien, m_r;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_inpr = '0;
    m_outr = '0;
    prn_q.delete();
    m_fgi = 0;
    m_ien = 0;
    m_r   = 0;
  endfunction

  // one printer character outstanding at most; FGO = nothing pending
  function automatic void m_step();
    bit o_fgi = m_fgi;
    bit o_fgo = (prn_q.size() == 0);
    bit o_ien = m_ien;
    if (bus.kbd_valid && !o_fgi) begin
      m_inpr = bus.kbd_data;
      m_fgi  = 1;
    end else if (bus.inp_ack && o_fgi) begin
      m_fgi = 0;
    end
    if (o_fgo && bus.out_load) begin
      prn_q.push_back(bus.out_data);
      m_outr = bus.out_data;
    end else if (!o_fgo && bus.prn_ready) begin
      void'(prn_q.pop_front());
    end
    if (bus.intr_ack || bus.iof) m_ien = 0;
    else if (bus.ion)            m_ien = 1;
    if (bus.intr_ack) m_r = 0;
    else if (!bus.fetch_phase && o_ien
             && (o_fgi || o_fgo)) m_r = 1;
  endfunction

  task automatic chk_all();
    bit e_fgo = (prn_q.size() == 0);
    chk("inpr", bus.inpr, m_inpr);
    chk("fgi", bus.fgi, m_fgi);
    chk("fgo", bus.fgo, e_fgo);
    chk("prn_valid", bus.prn_valid, !e_fgo);
    chk("prn_data", bus.prn_data, m_outr);
    chk("kbd_ready", bus.kbd_ready, !m_fgi);
    chk("ien", bus.ien, m_ien);
    chk("r", bus.r, m_r);
  endtask

  task automatic idle_in();
    bus.kbd_valid = 0;
    bus.prn_ready = 0;
    bus.inp_ack   = 0;
    bus.out_load  = 0;
    bus.ion       = 0;
    bus.iof       = 0;
    bus.intr_ack  = 0;
  endtask

  // inputs set after a negedge; one edge, then check at negedge
  task automatic cycle();
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk_all();
  endtask

  initial begin
    clr = 1;
    idle_in();
    bus.kbd_data    = '0;
    bus.out_data    = '0;
    bus.fetch_phase = 1;
    m_reset();
    #12 clr = 0;
    @(negedge clk);
    chk_all();
    chk("rst_fgo", bus.fgo, 1);
    chk("rst_kbd_ready", bus.kbd_ready, 1);

    // keyboard then INP
    bus.kbd_data = 8'h41; bus.kbd_valid = 1;
    cycle();
    chk("inpr_41", bus.inpr, 8'h41);
    chk("kbd_busy", bus.kbd_ready, 0);
    bus.kbd_data = 8'h42;
    cycle();
    cycle();
    chk("inpr_hold", bus.inpr, 8'h41);
    bus.inp_ack = 1;
    cycle();
    chk("fgi_ack", bus.fgi, 0);
    chk("inpr_keep", bus.inpr, 8'h41);
    bus.inp_ack = 0;
    cycle();
    chk("inpr_42", bus.inpr, 8'h42);
    bus.kbd_valid = 0;
    bus.inp_ack = 1;
    cycle();
    bus.inp_ack = 0;

    // printer
    bus.out_data = 8'h5A; bus.out_load = 1;
    cycle();
    chk("prn_5a", bus.prn_data, 8'h5A);
    chk("pv_set", bus.prn_valid, 1);
    bus.out_data = 8'h33;
    cycle();
    chk("ld_ignored", bus.prn_data, 8'h5A);
    bus.out_load = 0;
    repeat (5) cycle();
    bus.prn_ready = 1;
    cycle();
    chk("pv_clr", bus.prn_valid, 0);
    chk("fgo_set", bus.fgo, 1);
    chk("prn_keep", bus.prn_data, 8'h5A);
    cycle();
    bus.prn_ready = 0;

    // interrupt
    bus.fetch_phase = 1; bus.ion = 1;
    cycle();
    bus.ion = 0;
    cycle();
    chk("r_fetch", bus.r, 0);
    bus.fetch_phase = 0;
    cycle();
    chk("r_set", bus.r, 1);
    bus.intr_ack = 1;
    cycle();
    chk("r_ack", bus.r, 0);
    chk("ien_ack", bus.ien, 0);
    bus.intr_ack = 0;
    bus.ion = 1; bus.iof = 1;
    cycle();
    chk("ion_iof", bus.ien, 0);
    bus.iof = 0;
    cycle();
    bus.ion = 0; bus.intr_ack = 1;
    cycle();
    chk("ack_vs_set", bus.r, 0);
    bus.intr_ack = 0;
    bus.fetch_phase = 1;

    // asynchronous reset in SEND
    bus.out_data = 8'hC3; bus.out_load = 1;
    cycle();
    bus.out_load = 0;
    chk("send_pv", bus.prn_valid, 1);
    #2 clr = 1;
    #1;
    chk("async_pv", bus.prn_valid, 0);
    chk("async_fgo", bus.fgo, 1);
    m_reset();
    @(negedge clk);
    clr = 0;
    @(negedge clk);
    chk_all();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.kbd_data    = W'($urandom);
      bus.out_data    = W'($urandom);
      bus.kbd_valid   = ($urandom_range(1) == 1);
      bus.inp_ack     = ($urandom_range(4) == 0);
      bus.out_load    = ($urandom_range(4) == 0);
      bus.prn_ready   = ($urandom_range(2) == 0);
      bus.ion         = ($urandom_range(9) == 0);
      bus.iof         = ($urandom_range(19) == 0);
      bus.intr_ack    = ($urandom_range(9) == 0);
      bus.fetch_phase = ($urandom_range(1) == 1);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
